// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - MEM->WB pipeline register with 2-entry skid buffer and hazard query
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int DST_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [DATA_W-1:0] in_readdata,
    input  logic [DST_W-1:0]  in_dst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_regwrite,
    output logic              out_memtoreg,
    output logic [DATA_W-1:0] out_alu_out,
    output logic [DATA_W-1:0] out_readdata,
    output logic [DST_W-1:0]  out_dst,
    output logic [DATA_W-1:0] out_result,
    output logic [1:0]        count,
    input  logic [DST_W-1:0]  q_dst,
    output logic              q_hit,
    output logic              q_load
);

    // Entry layout: {regwrite, memtoreg, alu_out, readdata, dst}
    localparam int E_W = 2 * DATA_W + DST_W + 2;

    logic [E_W-1:0]    r_head;
    logic [E_W-1:0]    r_tail;
    logic [1:0]        r_count;

    logic [E_W-1:0]    w_in_entry;
    logic              w_push;
    logic              w_pop;
    logic              w_head_valid;
    logic              w_tail_valid;

    logic              w_h_rw;
    logic              w_h_mtr;
    logic [DATA_W-1:0] w_h_alu;
    logic [DATA_W-1:0] w_h_rd;
    logic [DST_W-1:0]  w_h_dst;
    logic              w_t_rw;
    logic              w_t_mtr;
    logic [DST_W-1:0]  w_t_dst;
    logic              w_h_match;
    logic              w_t_match;

    assign w_in_entry   = {in_regwrite, in_memtoreg, in_alu_out, in_readdata, in_dst};
    assign w_head_valid = (r_count != 2'd0);
    assign w_tail_valid = (r_count == 2'd2);

    // Handshake depends on registered count only, so WB stalls never reach MEM combinationally.
    assign in_ready  = (r_count != 2'd2);
    assign out_valid = w_head_valid;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (w_push && w_pop) begin
            r_head <= w_in_entry;
        end else if (w_push) begin
            if (r_count == 2'd0) begin
                r_head <= w_in_entry;
            end else begin
                r_tail <= w_in_entry;
            end
            r_count <= r_count + 2'd1;
        end else if (w_pop) begin
            r_head  <= r_tail;
            r_tail  <= '0;
            r_count <= r_count - 2'd1;
        end
    end

    assign {w_h_rw, w_h_mtr, w_h_alu, w_h_rd, w_h_dst} = r_head;
    assign w_t_rw  = r_tail[E_W-1];
    assign w_t_mtr = r_tail[E_W-2];
    assign w_t_dst = r_tail[DST_W-1:0];

    // Empty head presents a bubble: every field forced to zero.
    assign out_regwrite = w_head_valid & w_h_rw;
    assign out_memtoreg = w_head_valid & w_h_mtr;
    assign out_alu_out  = w_head_valid ? w_h_alu : '0;
    assign out_readdata = w_head_valid ? w_h_rd  : '0;
    assign out_dst      = w_head_valid ? w_h_dst : '0;
    assign out_result   = out_memtoreg ? out_readdata : out_alu_out;
    assign count        = r_count;

    assign w_h_match = w_head_valid & w_h_rw & (w_h_dst == q_dst) & (q_dst != '0);
    assign w_t_match = w_tail_valid & w_t_rw & (w_t_dst == q_dst) & (q_dst != '0);
    assign q_hit     = w_h_match | w_t_match;
    assign q_load    = w_t_match ? w_t_mtr : (w_h_match & w_h_mtr);

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb/tb_mem_wb_pipe.sv - table-driven self-checking bench for mem_wb_pipe
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, in_regwrite, in_memtoreg;
    logic [31:0] in_alu_out, in_readdata;
    logic [4:0]  in_dst;
    logic        out_valid, out_ready, out_regwrite, out_memtoreg;
    logic [31:0] out_alu_out, out_readdata, out_result;
    logic [4:0]  out_dst;
    logic [1:0]  count;
    logic [4:0]  q_dst;
    logic        q_hit, q_load;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_pipe #(.DATA_W(32), .DST_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .in_alu_out(in_alu_out), .in_readdata(in_readdata), .in_dst(in_dst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_regwrite(out_regwrite), .out_memtoreg(out_memtoreg),
        .out_alu_out(out_alu_out), .out_readdata(out_readdata), .out_dst(out_dst),
        .out_result(out_result), .count(count),
        .q_dst(q_dst), .q_hit(q_hit), .q_load(q_load)
    );

    typedef struct {
        logic        rst_n, flush, vin, rw, mtr;
        logic [31:0] alu, rd;
        logic [4:0]  dst;
        logic        ordy;
        logic [4:0]  qd;
        logic [1:0]  ecnt;
        logic        eovld, eirdy;
        logic [4:0]  edst;
        logic [31:0] eres;
        logic        eorw, eomtr, eqhit, eqload;
    } vec_t;

    vec_t cur;
    vec_t vq[$];

    task automatic s(input logic r, input logic fl, input logic vin, input logic rw, input logic mtr,
                     input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] dst,
                     input logic ordy, input logic [4:0] qd);
        cur.rst_n = r; cur.flush = fl; cur.vin = vin; cur.rw = rw; cur.mtr = mtr;
        cur.alu = alu; cur.rd = rd; cur.dst = dst; cur.ordy = ordy; cur.qd = qd;
    endtask

    task automatic e(input logic [1:0] cnt, input logic ovld, input logic irdy, input logic [4:0] dst,
                     input logic [31:0] res, input logic orw, input logic omtr,
                     input logic qh, input logic ql);
        cur.ecnt = cnt; cur.eovld = ovld; cur.eirdy = irdy; cur.edst = dst; cur.eres = res;
        cur.eorw = orw; cur.eomtr = omtr; cur.eqhit = qh; cur.eqload = ql;
        vq.push_back(cur);
    endtask

    task automatic chk(input int row, input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp_v);
        end
    endtask

    task automatic apply(input vec_t v);
        rst_n = v.rst_n; flush = v.flush; in_valid = v.vin; in_regwrite = v.rw;
        in_memtoreg = v.mtr; in_alu_out = v.alu; in_readdata = v.rd; in_dst = v.dst;
        out_ready = v.ordy; q_dst = v.qd;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_regwrite = 1'b0; in_memtoreg = 1'b0;
        in_alu_out = '0; in_readdata = '0; in_dst = '0; out_ready = 1'b0; q_dst = '0;

        // reset held two cycles with a record offered
        s(0,0,1,1,0,'h55,0,1,0,0); e(0,0,1,0,0,0,0,0,0);
        s(0,0,1,1,0,'h55,0,1,0,0); e(0,0,1,0,0,0,0,0,0);
        // streaming dst 1..8
        s(1,0,1,1,0,'h10,0,1,1,0); e(1,1,1,1,'h10,1,0,0,0);
        for (int k = 2; k <= 8; k++) begin
            s(1,0,1,1,0,32'('h10 + k - 1),0,5'(k),1,0); e(1,1,1,5'(k),32'('h10 + k - 1),1,0,0,0);
        end
        s(1,0,0,0,0,0,0,0,1,0);     e(0,0,1,0,0,0,0,0,0);
        // stall skid
        s(1,0,1,1,0,'h33,0,3,0,0);  e(1,1,1,3,'h33,1,0,0,0);
        s(1,0,1,1,0,'h44,0,4,0,0);  e(2,1,0,3,'h33,1,0,0,0);
        s(1,0,1,1,0,'h55,0,5,0,0);  e(2,1,0,3,'h33,1,0,0,0);
        s(1,0,1,1,0,'h55,0,5,1,0);  e(1,1,1,4,'h44,1,0,0,0);
        s(1,0,1,1,0,'h55,0,5,1,0);  e(1,1,1,5,'h55,1,0,0,0);
        s(1,0,0,0,0,0,0,0,1,0);     e(0,0,1,0,0,0,0,0,0);
        // flush from full, then flush with accepted push and pop
        s(1,0,1,1,0,'h66,0,6,0,0);  e(1,1,1,6,'h66,1,0,0,0);
        s(1,0,1,1,0,'h77,0,7,0,0);  e(2,1,0,6,'h66,1,0,0,0);
        s(1,1,1,1,0,'h99,0,9,0,0);  e(0,0,1,0,0,0,0,0,0);
        s(1,0,1,1,0,'hA0,0,10,0,0); e(1,1,1,10,'hA0,1,0,0,0);
        s(1,1,1,1,0,'h99,0,9,1,0);  e(0,0,1,0,0,0,0,0,0);
        s(1,0,0,0,0,0,0,0,1,0);     e(0,0,1,0,0,0,0,0,0);
        // hazard query
        s(1,0,1,1,0,'h70,'h700,7,0,7);  e(1,1,1,7,'h70,1,0,1,0);
        s(1,0,1,1,1,'h71,'h701,7,0,7);  e(2,1,0,7,'h70,1,0,1,1);
        s(1,0,0,0,0,0,0,0,0,0);         e(2,1,0,7,'h70,1,0,0,0);
        s(1,0,0,0,0,0,0,0,0,3);         e(2,1,0,7,'h70,1,0,0,0);
        s(1,0,0,0,0,0,0,0,1,7);         e(1,1,1,7,'h701,1,1,1,1);
        s(1,0,1,0,0,'hC,0,12,1,12);     e(1,1,1,12,'hC,0,0,0,0);
        s(1,0,1,1,1,'hD,'hE,12,0,12);   e(2,1,0,12,'hC,0,0,1,1);
        s(1,0,0,0,0,0,0,0,1,12);        e(1,1,1,12,'hE,1,1,1,1);
        s(1,0,0,0,0,0,0,0,1,12);        e(0,0,1,0,0,0,0,0,0);
        // result mux
        s(1,0,1,1,1,1,'hDEADBEEF,2,0,0); e(1,1,1,2,'hDEADBEEF,1,1,0,0);
        s(1,0,1,1,0,1,'hDEADBEEF,2,1,0); e(1,1,1,2,1,1,0,0,0);
        // reset mid-operation
        s(1,0,1,1,0,3,0,3,0,0);     e(2,1,0,2,1,1,0,0,0);
        s(0,0,1,1,0,3,0,3,0,0);     e(0,0,1,0,0,0,0,0,0);
        s(1,0,0,0,0,0,0,0,0,0);     e(0,0,1,0,0,0,0,0,0);

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i]);
            @(posedge clk);
            #1;
            chk(i, "count",        32'(count),        32'(vq[i].ecnt));
            chk(i, "out_valid",    32'(out_valid),    32'(vq[i].eovld));
            chk(i, "in_ready",     32'(in_ready),     32'(vq[i].eirdy));
            chk(i, "out_dst",      32'(out_dst),      32'(vq[i].edst));
            chk(i, "out_result",   out_result,        vq[i].eres);
            chk(i, "out_regwrite", 32'(out_regwrite), 32'(vq[i].eorw));
            chk(i, "out_memtoreg", 32'(out_memtoreg), 32'(vq[i].eomtr));
            chk(i, "q_hit",        32'(q_hit),        32'(vq[i].eqhit));
            chk(i, "q_load",       32'(q_load),       32'(vq[i].eqload));
        end

        // no combinational in_*->out_* or out_ready->in_ready path
        s(1,0,1,1,1,'h20,'h2020,20,0,0); apply(cur);
        @(posedge clk); #1;
        s(1,0,1,1,0,'h21,'h2121,21,0,0); apply(cur);
        @(posedge clk); #1;
        chk(100, "full_count", 32'(count), 32'd2);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk(100, "in_ready_no_comb", 32'(in_ready), 32'd0);
        in_alu_out = 32'hFFFF_FFFF; in_readdata = 32'h1234_5678; in_dst = 5'd31; in_memtoreg = 1'b0;
        #1;
        chk(100, "out_dst_no_comb",  32'(out_dst), 32'd20);
        chk(100, "out_readdata_hold", out_readdata, 32'h2020);
        chk(100, "out_alu_hold",      out_alu_out,  32'h20);
        @(posedge clk); #1;
        chk(101, "drain_dst",  32'(out_dst), 32'd21);
        chk(101, "drain_res",  out_result,   32'h21);
        @(posedge clk); #1;
        chk(102, "drain_empty", 32'(count), 32'd0);
        chk(102, "bubble_alu",  out_alu_out, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM→WB pipeline register, successor to the fixed-width stall/flush register. Holds up to two in-flight writeback records in a 2-entry skid buffer, so that a WB-side stall never propagates combinationally back into MEM. Adds valid/ready handshaking, configurable data and register-index widths, an occupancy output, and a register-hazard query port for the forwarding/interlock unit. Sits between the MEM stage and the register-file writeback logic.

## Interface
- DATA_W, 32, width of alu_out and readdata fields
- DST_W, 5, width of destination register index
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low
- flush  input  1  discard all held entries and any transfer in the same cycle
- in_valid  input  1  MEM presents a record
- in_ready  output  1  buffer can accept; high when count < 2
- in_regwrite  input  1  record writes the register file
- in_memtoreg  input  1  result comes from readdata (else alu_out)
- in_alu_out  input  DATA_W  ALU result
- in_readdata  input  DATA_W  load data
- in_dst  input  DST_W  destination register index
- out_valid  output  1  head record valid
- out_ready  input  1  WB consumes head (replaces WB stall: out_ready = ~stall)
- out_regwrite, out_memtoreg  output  1 each  head control fields
- out_alu_out, out_readdata  output  DATA_W each  head data fields
- out_dst  output  DST_W  head destination
- out_result  output  DATA_W  out_memtoreg ? out_readdata : out_alu_out
- count  output  2  entries held, 0..2
- q_dst  input  DST_W  hazard query register index
- q_hit  output  1  some valid entry has regwrite=1 and dst==q_dst, q_dst≠0
- q_load  output  1  q_hit and the youngest matching entry has memtoreg=1

## Operation
- Storage: two entries (head, tail) plus a 2-bit count register; entries are in order, head oldest.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != 2); depends on registers only.
- out_valid = (count != 0). When out_valid=0, every out_* field and out_result are 0 (bubble: regwrite never asserted on an empty head).
- Next state (priority top-down):
  - rst_n=0: count=0, both entries cleared to 0.
  - flush=1: count=0; the push (if any) is accepted then dropped; pop is ignored.
  - push & pop: count unchanged; count=1: new record becomes head; count=2 impossible (in_ready=0).
  - push only: record written at position count; count+1.
  - pop only: tail shifts to head; count−1; vacated entry cleared to 0.
  - neither: hold.
- Hazard query combinational over valid entries only; entries beyond count never match. q_dst=0 always gives q_hit=q_load=0. "Youngest" = tail when count=2 and tail matches, else head.
- Widths: no arithmetic; fields pass through unchanged.

## Timing
- Latency in→out: 1 cycle (record accepted at edge N is visible on out_* after edge N).
- Throughput: 1 record/cycle while out_ready=1.
- No combinational path in_*→out_* or out_ready→in_ready.
- After out_ready drops with count=1, one more record is absorbed (count=2), then in_ready=0 from the next cycle.
- Reset mid-operation: after the reset edge count=0, in_ready=1, all outputs 0; in-flight records lost.
- Flush with rst_n=1: result as reset, entries cleared, visible after the edge.
- Query outputs reflect state between edges, including a record pushed on the preceding edge.

## Test plan
- Reset: hold rst_n=0 two cycles with in_valid=1 → count=0, out_valid=0, in_ready=1, all out_* 0; release → first record on out_* one cycle later.
- Streaming: out_ready=1, push dst=1..8, alu_out=0x10..0x17 back-to-back → out appears in order one cycle delayed, count stays 1, in_ready never drops.
- Stall skid: count=1 (dst=3), out_ready=0, push dst=4 → count=2, in_ready=0; a further push of dst=5 is not accepted; out_ready=1 → dst 3, then 4 emerge, then dst=5 accepted.
- Flush: count=2, flush=1 with push dst=9 → next cycle count=0, out_valid=0, out_regwrite=0; dst 9 never appears.
- Hazard: head dst=7 regwrite=1 memtoreg=0, tail dst=7 memtoreg=1, q_dst=7 → q_hit=1, q_load=1; q_dst=0 → 0,0; regwrite=0 entries → q_hit=0.
- Result mux: memtoreg=1, readdata=0xDEADBEEF, alu_out=0x1 → out_result=0xDEADBEEF; memtoreg=0 → 0x1.
